// File: rtl/mul_pipe.sv
// mul_pipe: fully pipelined 32x32 multiplier with speculative-tag kill/confirm.
// Ports: clk; reset (async, active-low); issue_valid, ex_src1/2, src1/2_signed,
//   sel_lohi, rrftag, dstval, spectag, specbit (issued op); prmiss, prsuccess,
//   prtag, specfixtag (branch resolution); exrslt, exdst, rrf_we, kill_spec,
//   rslt_valid, inflight (result stage / occupancy).
// Define MUL_DEEP_PIPE_EN for a 4-stage pipe with a partial-product register;
//   default build is 3 stages (operand, multiply, select/output).
module mul_pipe (
   input  logic        clk,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic [31:0] ex_src1,
   input  logic [31:0] ex_src2,
   input  logic        src1_signed,
   input  logic        src2_signed,
   input  logic        sel_lohi,
   input  logic [5:0]  rrftag,
   input  logic        dstval,
   input  logic [4:0]  spectag,
   input  logic        specbit,
   input  logic        prmiss,
   input  logic        prsuccess,
   input  logic [4:0]  prtag,
   input  logic [4:0]  specfixtag,
   output logic [31:0] exrslt,
   output logic [5:0]  exdst,
   output logic        rrf_we,
   output logic        kill_spec,
   output logic        rslt_valid,
   output logic [2:0]  inflight
);

`ifdef MUL_DEEP_PIPE_EN
   localparam int L = 4;
`else
   localparam int L = 3;
`endif

   typedef struct packed {
      logic       valid;
      logic [5:0] rrftag;
      logic       dstval;
      logic [4:0] spectag;
      logic       specbit;
      logic       sel_lohi;
   } tag_t;

   // Branch resolution applied to one op; a miss wins over a success.
   // specbit is forced low on bubbles so kill_spec never fires on one.
   function automatic tag_t resolve(
      input tag_t       t,
      input logic       pm,
      input logic       ps,
      input logic [4:0] pt,
      input logic [4:0] sft
   );
      tag_t r;
      r = t;
      if (pm) begin
         if ((t.spectag & sft) != 5'd0) r.valid = 1'b0;
      end else if (ps) begin
         if (t.spectag == pt) r.specbit = 1'b0;
      end
      r.specbit = r.specbit & r.valid;
      return r;
   endfunction

   tag_t        tag_d [L];
   tag_t        tag_q [L];
   logic [2:0]  inflight_d, inflight_q;

   logic [32:0] a_d, a_q;
   logic [32:0] b_d, b_q;
   logic [63:0] prod_d, prod_q;
   logic [31:0] res_d, res_q;
`ifdef MUL_DEEP_PIPE_EN
   logic [49:0] pplo_d, pplo_q;
   logic [47:0] pphi_d, pphi_q;
`endif

   always_comb begin
      tag_d[0] = resolve(
         tag_t'({issue_valid, rrftag, dstval, spectag, specbit, sel_lohi}),
         prmiss, prsuccess, prtag, specfixtag);
      for (int i = 1; i < L; i++) begin
         tag_d[i] = resolve(tag_q[i-1], prmiss, prsuccess, prtag, specfixtag);
      end
      inflight_d = '0;
      for (int i = 0; i < L; i++) begin
         inflight_d = inflight_d + {2'b00, tag_d[i].valid};
      end
   end

   // Only product bits [63:0] are ever selected, so the datapath
   // is computed modulo 2^64.
   always_comb begin
      a_d = {src1_signed & ex_src1[31], ex_src1};
      b_d = {src2_signed & ex_src2[31], ex_src2};
`ifdef MUL_DEEP_PIPE_EN
      // a * b_lo (b_lo unsigned) plus (a * b_hi) << 16, b_hi signed.
      pplo_d = {{17{a_q[32]}}, a_q} * {34'd0, b_q[15:0]};
      pphi_d = {{15{a_q[32]}}, a_q} * {{31{b_q[32]}}, b_q[32:16]};
      prod_d = {{14{pplo_q[49]}}, pplo_q} + {pphi_q, 16'd0};
`else
      prod_d = {{31{a_q[32]}}, a_q} * {{31{b_q[32]}}, b_q};
`endif
      res_d = tag_q[L-2].sel_lohi ? prod_q[63:32] : prod_q[31:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < L; i++) tag_q[i] <= '0;
         inflight_q <= '0;
         a_q        <= '0;
         b_q        <= '0;
         prod_q     <= '0;
         res_q      <= '0;
`ifdef MUL_DEEP_PIPE_EN
         pplo_q     <= '0;
         pphi_q     <= '0;
`endif
      end else begin
         for (int i = 0; i < L; i++) tag_q[i] <= tag_d[i];
         inflight_q <= inflight_d;
         a_q        <= a_d;
         b_q        <= b_d;
         prod_q     <= prod_d;
         res_q      <= res_d;
`ifdef MUL_DEEP_PIPE_EN
         pplo_q     <= pplo_d;
         pphi_q     <= pphi_d;
`endif
      end
   end

   assign rslt_valid = tag_q[L-1].valid;
   assign rrf_we     = rslt_valid & tag_q[L-1].dstval;
   assign kill_spec  = prmiss & tag_q[L-1].specbit;
   assign exdst      = rslt_valid ? tag_q[L-1].rrftag : 6'd0;
   assign exrslt     = rslt_valid ? res_q : 32'd0;
   assign inflight   = inflight_q;

endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: scoreboard bench for mul_pipe; expected results are queued
//   at issue, adjusted by branch broadcasts, and checked at their due cycle.
module tb_mul_pipe;

`ifdef MUL_DEEP_PIPE_EN
   localparam int L = 4;
`else
   localparam int L = 3;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic [31:0] ex_src1, ex_src2;
   logic        src1_signed, src2_signed, sel_lohi;
   logic [5:0]  rrftag;
   logic        dstval;
   logic [4:0]  spectag;
   logic        specbit;
   logic        prmiss, prsuccess;
   logic [4:0]  prtag, specfixtag;
   logic [31:0] exrslt;
   logic [5:0]  exdst;
   logic        rrf_we, kill_spec, rslt_valid;
   logic [2:0]  inflight;

   mul_pipe dut (
      .clk(clk), .reset(reset), .issue_valid(issue_valid),
      .ex_src1(ex_src1), .ex_src2(ex_src2),
      .src1_signed(src1_signed), .src2_signed(src2_signed),
      .sel_lohi(sel_lohi), .rrftag(rrftag), .dstval(dstval),
      .spectag(spectag), .specbit(specbit),
      .prmiss(prmiss), .prsuccess(prsuccess),
      .prtag(prtag), .specfixtag(specfixtag),
      .exrslt(exrslt), .exdst(exdst), .rrf_we(rrf_we),
      .kill_spec(kill_spec), .rslt_valid(rslt_valid),
      .inflight(inflight)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] res;
      logic [5:0]  tag;
      logic        dstval;
      logic [4:0]  spectag;
      logic        specbit;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_we = 0;
   int   exp_inf;

   function automatic logic [31:0] ref_mul(
      input logic [31:0] a, input logic [31:0] b,
      input logic sa, input logic sbb, input logic hi);
      logic [65:0] x, y, p;
      x = {{34{sa & a[31]}}, a};
      y = {{34{sbb & b[31]}}, b};
      p = x * y;
      return hi ? p[63:32] : p[31:0];
   endfunction

   // Model of branch resolution on queued ops still inside the pipe.
   always @(posedge clk) begin
      if (!reset) begin
         sb.delete();
      end else if (prmiss) begin
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due > cyc && (sb[i].spectag & specfixtag) != 5'd0)
               sb.delete(i);
         end
      end else if (prsuccess) begin
         foreach (sb[i]) begin
            if (sb[i].due > cyc && sb[i].spectag == prtag)
               sb[i].specbit = 1'b0;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (!reset) begin
         n_checks++;
         if ({rslt_valid, rrf_we, kill_spec, inflight, exdst, exrslt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: vld=%b we=%b ks=%b inf=%0d dst=%0d rs=%h want all 0",
                     rslt_valid, rrf_we, kill_spec, inflight, exdst, exrslt);
         end
      end else begin
         exp_inf = 0;
         foreach (sb[i]) if (sb[i].due <= cyc + L - 1) exp_inf++;
         n_checks++;
         if (inflight !== 3'(exp_inf)) begin
            n_fail++;
            $display("FAIL inflight: got %0d want %0d (cyc %0d)", inflight, exp_inf, cyc);
         end
         if (sb.size() > 0 && sb[0].due < cyc) begin
            n_fail++;
            $display("FAIL lost_result: due %0d never seen", sb[0].due);
            void'(sb.pop_front());
         end
         n_checks++;
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (rslt_valid !== 1'b1 || exrslt !== e.res || exdst !== e.tag ||
                rrf_we !== e.dstval || kill_spec !== (prmiss & e.specbit)) begin
               n_fail++;
               $display("FAIL result: got v=%b r=%h d=%0d we=%b ks=%b want v=1 r=%h d=%0d we=%b ks=%b",
                        rslt_valid, exrslt, exdst, rrf_we, kill_spec,
                        e.res, e.tag, e.dstval, prmiss & e.specbit);
            end
         end else begin
            if (rslt_valid !== 1'b0 || rrf_we !== 1'b0 || kill_spec !== 1'b0 ||
                exrslt !== 32'd0 || exdst !== 6'd0) begin
               n_fail++;
               $display("FAIL bubble: got v=%b we=%b ks=%b r=%h d=%0d want all 0",
                        rslt_valid, rrf_we, kill_spec, exrslt, exdst);
            end
         end
         if (rrf_we === 1'b1) n_we++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      ex_src1 = '0; ex_src2 = '0;
      src1_signed = 1'b0; src2_signed = 1'b0; sel_lohi = 1'b0;
      rrftag = '0; dstval = 1'b0; spectag = '0; specbit = 1'b0;
   endtask

   task automatic drive_op(
      input logic [31:0] a, input logic [31:0] b,
      input logic sa, input logic sbb, input logic hi,
      input logic [5:0] tg, input logic dv,
      input logic [4:0] st, input logic sbit);
      exp_t x;
      issue_valid = 1'b1;
      ex_src1 = a; ex_src2 = b;
      src1_signed = sa; src2_signed = sbb; sel_lohi = hi;
      rrftag = tg; dstval = dv; spectag = st; specbit = sbit;
      x.due = cyc + L;
      x.res = ref_mul(a, b, sa, sbb, hi);
      x.tag = tg;
      x.dstval = dv;
      x.spectag = st;
      x.specbit = sbit;
      sb.push_back(x);
   endtask

   task automatic drain();
      idle();
      repeat (L + 1) tick();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle();
      prmiss = 1'b0; prsuccess = 1'b0; prtag = '0; specfixtag = '0;
      repeat (3) tick();
      @(negedge clk);
      n_checks++;
      if (rslt_valid !== 1'b0 || inflight !== 3'd0) begin
         n_fail++;
         $display("FAIL test_reset: vld=%b inf=%0d want 0 0", rslt_valid, inflight);
      end
      tick();
      reset = 1'b1;
      drive_op(32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 6'd3, 1'b1, 5'd0, 1'b0);
      tick();
      @(negedge clk);
      n_checks++;
      if (inflight !== 3'd1) begin
         n_fail++;
         $display("FAIL first_accept: inf=%0d want 1", inflight);
      end
      drain();
   endtask

   task automatic test_umax();
      drive_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1,
               6'd5, 1'b1, 5'd0, 1'b0);
      tick();
      idle();
      repeat (L - 2) tick();
      @(negedge clk);
      n_checks++;
      if (rrf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL umax_early: we=%b want 0", rrf_we);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (exrslt !== 32'hFFFF_FFFE || exdst !== 6'd5 || rrf_we !== 1'b1) begin
         n_fail++;
         $display("FAIL umax: r=%h d=%0d we=%b want fffffffe 5 1",
                  exrslt, exdst, rrf_we);
      end
      drain();
   endtask

   task automatic test_signed();
      drive_op(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1, 1'b0, 6'd8, 1'b1, 5'd0, 1'b0);
      tick();
      drive_op(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1, 1'b1, 6'd9, 1'b1, 5'd0, 1'b0);
      tick();
      drive_op(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 1'b1, 6'd10, 1'b0, 5'd0, 1'b0);
      tick();
      drive_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 6'd11, 1'b1, 5'd0, 1'b0);
      tick();
      drain();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 3) == 0) idle();
         else drive_op($urandom, $urandom,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)));
         tick();
      end
      drain();
   endtask

   task automatic test_kill();
      int we0;
      we0 = n_we;
      drive_op(32'd11, 32'd13, 1'b0, 1'b0, 1'b0, 6'd10, 1'b1, 5'd1, 1'b1);
      tick();
      drive_op(32'd17, 32'd19, 1'b0, 1'b0, 1'b0, 6'd11, 1'b1, 5'd2, 1'b1);
      tick();
      drive_op(32'd23, 32'd29, 1'b0, 1'b0, 1'b0, 6'd12, 1'b1, 5'd4, 1'b1);
      tick();
      idle();
      prmiss = 1'b1; specfixtag = 5'h06;
      @(negedge clk);
      n_checks++;
      if (inflight !== 3'd3) begin
         n_fail++;
         $display("FAIL kill_pre: inf=%0d want 3", inflight);
      end
      tick();
      prmiss = 1'b0; specfixtag = '0;
      @(negedge clk);
      n_checks++;
      if (inflight !== 3'(L - 3)) begin
         n_fail++;
         $display("FAIL kill_post: inf=%0d want %0d", inflight, L - 3);
      end
      drain();
      n_checks++;
      if (n_we - we0 !== 1) begin
         n_fail++;
         $display("FAIL kill_retire: got %0d writes want 1", n_we - we0);
      end
   endtask

   task automatic test_success();
      drive_op(32'd100, 32'd200, 1'b0, 1'b0, 1'b0, 6'd20, 1'b1, 5'd2, 1'b1);
      tick();
      idle();
      prsuccess = 1'b1; prtag = 5'd2;
      tick();
      prsuccess = 1'b0; prtag = '0;
      repeat (L - 2) tick();
      prmiss = 1'b1; specfixtag = 5'h02;
      @(negedge clk);
      n_checks++;
      if (kill_spec !== 1'b0 || rrf_we !== 1'b1) begin
         n_fail++;
         $display("FAIL success: ks=%b we=%b want 0 1", kill_spec, rrf_we);
      end
      tick();
      prmiss = 1'b0; specfixtag = '0;
      drain();
   endtask

   task automatic test_both();
      int we0;
      we0 = n_we;
      drive_op(32'd5, 32'd9, 1'b0, 1'b0, 1'b0, 6'd30, 1'b1, 5'd1, 1'b1);
      tick();
      drive_op(32'd6, 32'd9, 1'b0, 1'b0, 1'b0, 6'd31, 1'b1, 5'd1, 1'b1);
      prmiss = 1'b1; prsuccess = 1'b1; prtag = 5'd1; specfixtag = 5'h01;
      tick();
      prmiss = 1'b0; prsuccess = 1'b0; prtag = '0; specfixtag = '0;
      idle();
      @(negedge clk);
      n_checks++;
      if (inflight !== 3'd0) begin
         n_fail++;
         $display("FAIL both_inflight: inf=%0d want 0", inflight);
      end
      drain();
      n_checks++;
      if (n_we !== we0) begin
         n_fail++;
         $display("FAIL both_we: got %0d writes want 0", n_we - we0);
      end
   endtask

   task automatic test_reset_mid();
      int we0;
      drive_op(32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 6'd40, 1'b1, 5'd0, 1'b0);
      tick();
      drive_op(32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 6'd41, 1'b1, 5'd0, 1'b0);
      tick();
      idle();
      @(negedge clk);
      n_checks++;
      if (inflight !== 3'd2) begin
         n_fail++;
         $display("FAIL rmid_pre: inf=%0d want 2", inflight);
      end
      #1;
      reset = 1'b0;
      sb.delete();
      we0 = n_we;
      tick();
      tick();
      reset = 1'b1;
      repeat (L + 1) tick();
      @(negedge clk);
      n_checks++;
      if (n_we !== we0 || inflight !== 3'd0) begin
         n_fail++;
         $display("FAIL rmid_post: writes=%0d inf=%0d want 0 0", n_we - we0, inflight);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_umax();
      test_signed();
      test_back_to_back();
      test_kill();
      test_success();
      test_both();
      test_reset_mid();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL leftover: %0d results never seen", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mul_pipe.md
MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-003 SHALL have ports issue_valid  in  1, ex_src1 / ex_src2  in  32 each, src1_signed / src2_signed / sel_lohi  in  1 each.
REQ-004 SHALL have ports rrftag  in  6, dstval  in  1, spectag  in  5, specbit  in  1; these form the issued-op tag.
REQ-005 SHALL have ports prmiss, prsuccess  in  1 each; prtag, specfixtag  in  5 each; these are branch-resolution broadcasts.
REQ-006 SHALL have port exrslt  out  32  final result.
REQ-007 SHALL have port exdst  out  6  destination rename tag.
REQ-008 SHALL have port rrf_we  out  1  rename-register write enable.
REQ-009 SHALL have port kill_spec  out  1  result-squash qualifier.
REQ-010 SHALL have port rslt_valid  out  1  result-stage occupancy.
REQ-011 SHALL have port inflight  out  3  count of valid ops in the pipe.

Function
REQ-012 SHALL be fully pipelined, with no backpressure: one op is accepted every cycle that issue_valid=1.
REQ-013 SHALL form operands as 33-bit values: bit 32 = signed flag AND bit 31, else 0.
REQ-014 SHALL compute the 66-bit product; exrslt = bits[31:0] when sel_lohi=0, bits[63:32] when sel_lohi=1.
REQ-015 SHALL have a latency of exactly L cycles: an op accepted at edge N appears on the outputs after edge N+L-1. L=3 by default; see Configuration.
REQ-016 SHALL carry, in each stage register: valid, rrftag, dstval, spectag, specbit, sel_lohi and partial data.
REQ-017 SHALL, on prmiss=1, clear valid in every stage, and in the incoming op, where (spectag & specfixtag) != 0; other ops proceed unchanged.
REQ-018 SHALL, on prsuccess=1, clear specbit in every stage, and in the incoming op, where spectag == prtag.
REQ-019 SHALL give prmiss precedence when prmiss and prsuccess are both 1; the specbit update is skipped that cycle.
REQ-020 SHALL drive rrf_we = rslt_valid & dstval of the output stage.
REQ-021 SHALL drive kill_spec = prmiss & output-stage specbit (combinational), so a result squashed this cycle is ignored by the reservation stations.
REQ-022 SHALL drive exdst = output-stage rrftag, and drive exrslt and exdst to 0 when rslt_valid=0.
REQ-023 SHALL update inflight each cycle as: previous count + accepted - retired - killed. It never exceeds L and never wraps.
REQ-024 SHALL accept an op that arrives in the same cycle as a prmiss that kills it, and then discard it: it adds no inflight increment.

Reset
REQ-025 SHALL, while reset=0, hold all stage valid bits, exrslt, exdst, rrf_we, kill_spec, rslt_valid and inflight at 0.
REQ-026 SHALL discard ops in flight when reset is asserted mid-operation; no result for them appears after reset releases.
REQ-027 SHALL accept a new op on the first rising edge after reset returns to 1.

Configuration
REQ-028 SHALL use macro MUL_DEEP_PIPE_EN to select pipeline depth.
REQ-029 SHALL, with MUL_DEEP_PIPE_EN defined, insert an extra partial-product register stage: L=4, and inflight may reach 4.
REQ-030 SHALL, without MUL_DEEP_PIPE_EN, use L=3: operand stage, multiply stage, select/output stage.
REQ-031 SHALL apply REQ-017 through REQ-019 identically to every stage in both configurations.

Verification
REQ-032 SHALL cover: unsigned 0xFFFFFFFF x 0xFFFFFFFF, sel_lohi=1, rrftag=5, dstval=1 -> exrslt=0xFFFFFFFE, exdst=5, rrf_we=1 exactly L cycles later.
REQ-033 SHALL cover: signed -2 x 3 (0xFFFFFFFE x 3), both signed, sel_lohi=0 -> 0xFFFFFFFA; with sel_lohi=1 -> 0xFFFFFFFF.
REQ-034 SHALL cover: three back-to-back ops with spectag 1, 2, 4; prmiss with specfixtag=0x06 one cycle later -> only the spectag-1 result retires; inflight drops by 2.
REQ-035 SHALL cover: op with specbit=1, spectag=2; prsuccess with prtag=2 mid-pipe, then prmiss at its output cycle -> kill_spec=0.
REQ-036 SHALL cover: prmiss and prsuccess together, spectag=prtag=1, specfixtag=0x01 -> op killed, no rrf_we.
REQ-037 SHALL cover: reset asserted with 2 ops in flight -> no rrf_we after release, and inflight=0.
